// File: rtl/mutex_sched_pkg.sv
// Shared types and helpers for the round-robin mutex grant scheduler.
// The optional forced-revoke feature is enabled by MUTEX_GRANT_TIMEOUT_EN.
package mutex_sched_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'b00,
    BUSY    = 2'b01,
    RECOVER = 2'b10
  } state_t;

  localparam int NODES_DEF    = 3;
  localparam int MAX_HOLD_DEF = 15;

  // Wide result; callers size-cast down to their node count.
  function automatic logic [31:0] onehot(input logic [31:0] idx);
    return 32'd1 << idx[4:0];
  endfunction

endpackage

// File: rtl/mutex_grant_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NODES.
module rr_pick #(
  parameter int NODES = 3,
  parameter int PTR_W = 2
) (
  input  logic [NODES-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] sel,
  output logic             valid
);

  always_comb begin
    int j;
    logic [PTR_W-1:0] idx;
    sel   = '0;
    valid = 1'b0;
    j     = 0;
    idx   = '0;
    for (int i = 0; i < NODES; i++) begin
      j = int'(ptr) + i;
      if (j >= NODES) j = j - NODES;
      idx = PTR_W'(j);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        sel   = idx;
      end
    end
  end

endmodule

// File: rtl/mutex_grant_scheduler.sv
// Round-robin mutual-exclusion scheduler with a one-cycle recovery gap.
// Define MUTEX_GRANT_TIMEOUT_EN to revoke grants held past MAX_HOLD.
module mutex_grant_scheduler
  import mutex_sched_pkg::*;
#(
  parameter int NODES    = NODES_DEF,
  parameter int OWNER_W  = $clog2(NODES),
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NODES-1:0]   req,
  input  logic [NODES-1:0]   rel,
  output logic [NODES-1:0]   grant,
  output logic [OWNER_W-1:0] owner,
  output logic               busy,
  output logic [HOLD_W-1:0]  hold_cnt,
  output logic               proto_err,
  output logic               timeout
);

  state_t             state_q;
  logic [NODES-1:0]   grant_q;
  logic [OWNER_W-1:0] owner_q;
  logic [OWNER_W-1:0] ptr_q;
  logic [HOLD_W-1:0]  hold_q;
  logic               perr_q;

  logic [OWNER_W-1:0] pick_sel;
  logic               pick_vld;
  logic [OWNER_W-1:0] ptr_nxt;
  logic               own_rel;
  logic               bad_rel;

  rr_pick #(
    .NODES (NODES),
    .PTR_W (OWNER_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .sel   (pick_sel),
    .valid (pick_vld)
  );

  // grant_q is one-hot on the owner, so it doubles as the owner mask.
  assign own_rel = |(rel & grant_q);
  assign bad_rel = |(rel & ~grant_q);

  assign ptr_nxt = (int'(pick_sel) == NODES - 1)
                 ? '0 : pick_sel + 1'b1;

`ifdef MUTEX_GRANT_TIMEOUT_EN
  logic tmo_q;
  logic at_lim;
  assign at_lim = (hold_q == HOLD_W'(MAX_HOLD));
  assign timeout = tmo_q;
`else
  logic [HOLD_W-1:0] unused_lim;
  assign unused_lim = HOLD_W'(MAX_HOLD);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FREE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      perr_q  <= 1'b0;
`ifdef MUTEX_GRANT_TIMEOUT_EN
      tmo_q   <= 1'b0;
`endif
    end else begin
      perr_q <= bad_rel;
`ifdef MUTEX_GRANT_TIMEOUT_EN
      tmo_q  <= 1'b0;
`endif
      case (state_q)
        FREE: begin
          if (pick_vld) begin
            state_q <= BUSY;
            grant_q <= NODES'(onehot(32'(pick_sel)));
            owner_q <= pick_sel;
            ptr_q   <= ptr_nxt;
            hold_q  <= '0;
          end
        end
        BUSY: begin
          if (own_rel) begin
            state_q <= RECOVER;
            grant_q <= '0;
            owner_q <= '0;
            hold_q  <= '0;
`ifdef MUTEX_GRANT_TIMEOUT_EN
          end else if (at_lim) begin
            state_q <= RECOVER;
            grant_q <= '0;
            owner_q <= '0;
            hold_q  <= '0;
            tmo_q   <= 1'b1;
`endif
          end else if (hold_q != '1) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        RECOVER: begin
          state_q <= FREE;
        end
        default: begin
          state_q <= FREE;
          grant_q <= '0;
          owner_q <= '0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign busy      = (state_q == BUSY);
  assign hold_cnt  = hold_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_mutex_grant_scheduler.sv
// Directed vector table plus hand sequences and a random invariant sweep
// for mutex_grant_scheduler.
module tb_mutex_grant_scheduler;

  logic       clock;
  logic       reset;
  logic [2:0] req;
  logic [2:0] rel;
  logic [2:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic [3:0] hold_cnt;
  logic       proto_err;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  mutex_grant_scheduler dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .rel       (rel),
    .grant     (grant),
    .owner     (owner),
    .busy      (busy),
    .hold_cnt  (hold_cnt),
    .proto_err (proto_err),
    .timeout   (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] req;
    logic [2:0] rel;
    logic [2:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       perr;
    logic [3:0] hold;
  } vec_t;

  vec_t vt[29];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    req = '0;
    rel = '0;
  endtask

  initial begin
    logic [2:0] p1;
    logic [2:0] p2;

    //            req     rel     grant  own   bsy   perr  hold
    vt[0]  = '{3'b010, 3'b000, 3'b010, 2'd1, 1'b1, 1'b0, 4'd0};
    vt[1]  = '{3'b010, 3'b000, 3'b010, 2'd1, 1'b1, 1'b0, 4'd1};
    vt[2]  = '{3'b000, 3'b000, 3'b010, 2'd1, 1'b1, 1'b0, 4'd2};
    vt[3]  = '{3'b000, 3'b010, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0};
    vt[4]  = '{3'b111, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0};
    vt[5]  = '{3'b111, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0, 4'd0};
    vt[6]  = '{3'b111, 3'b100, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0};
    vt[7]  = '{3'b111, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0};
    vt[8]  = '{3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0, 4'd0};
    vt[9]  = '{3'b111, 3'b001, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0};
    vt[10] = '{3'b111, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0};
    vt[11] = '{3'b111, 3'b000, 3'b010, 2'd1, 1'b1, 1'b0, 4'd0};
    vt[12] = '{3'b111, 3'b010, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0};
    vt[13] = '{3'b111, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0};
    vt[14] = '{3'b111, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0, 4'd0};
    vt[15] = '{3'b000, 3'b100, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0};
    vt[16] = '{3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0};
    vt[17] = '{3'b000, 3'b001, 3'b000, 2'd0, 1'b0, 1'b1, 4'd0};
    vt[18] = '{3'b001, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0, 4'd0};
    vt[19] = '{3'b000, 3'b100, 3'b001, 2'd0, 1'b1, 1'b1, 4'd1};
    vt[20] = '{3'b000, 3'b001, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0};
    vt[21] = '{3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0};
    vt[22] = '{3'b100, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0, 4'd0};
    vt[23] = '{3'b000, 3'b101, 3'b000, 2'd0, 1'b0, 1'b1, 4'd0};
    vt[24] = '{3'b000, 3'b010, 3'b000, 2'd0, 1'b0, 1'b1, 4'd0};
    vt[25] = '{3'b011, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0, 4'd0};
    vt[26] = '{3'b011, 3'b001, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0};
    vt[27] = '{3'b011, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 4'd0};
    vt[28] = '{3'b011, 3'b000, 3'b010, 2'd1, 1'b1, 1'b0, 4'd0};

    reset = 1'b0;
    req   = '0;
    rel   = '0;
    #12;
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst owner", 32'(owner), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst hold", 32'(hold_cnt), 32'd0);
    chk("rst perr", 32'(proto_err), 32'd0);
    chk("rst tmo", 32'(timeout), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 29; i++) begin
      req = vt[i].req;
      rel = vt[i].rel;
      step();
      chk($sformatf("row%0d grant", i), 32'(grant), 32'(vt[i].grant));
      chk($sformatf("row%0d owner", i), 32'(owner), 32'(vt[i].owner));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(vt[i].busy));
      chk($sformatf("row%0d perr", i), 32'(proto_err), 32'(vt[i].perr));
      chk($sformatf("row%0d hold", i), 32'(hold_cnt), 32'(vt[i].hold));
    end

    // owner 1 busy, ptr at 2: release, then grant node 2
    req = '0; rel = 3'b010; step();
    rel = '0; step();
    req = 3'b100; step();
    chk("pre-rst grant", 32'(grant), 32'b100);
    chk("pre-rst owner", 32'(owner), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("async rst grant", 32'(grant), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    #1 reset = 1'b1;
    step();
    chk("post-rst grant", 32'(grant), 32'b100);
    chk("post-rst owner", 32'(owner), 32'd2);
    req = '0; rel = 3'b100; step();
    rel = '0; step();

    // hold counter and optional revoke, node 0 never releases
    pulse_reset();
    req = 3'b001; step();
    chk("hold grant", 32'(grant), 32'b001);
    req = '0;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk($sformatf("hold%0d", i), 32'(hold_cnt), 32'(i));
    end
    step();
`ifdef MUTEX_GRANT_TIMEOUT_EN
    chk("revoke grant", 32'(grant), 32'd0);
    chk("revoke tmo", 32'(timeout), 32'd1);
    chk("revoke busy", 32'(busy), 32'd0);
    req = 3'b011; step();
    chk("post-revoke tmo", 32'(timeout), 32'd0);
    chk("post-revoke idle", 32'(grant), 32'd0);
    step();
    chk("post-revoke grant", 32'(grant), 32'b010);
    chk("post-revoke owner", 32'(owner), 32'd1);
    req = '0; rel = 3'b010; step();
    rel = '0; step();
`else
    chk("sat grant", 32'(grant), 32'b001);
    chk("sat hold", 32'(hold_cnt), 32'd15);
    chk("sat tmo", 32'(timeout), 32'd0);
    rel = 3'b001; step();
    rel = '0;
    chk("sat rel grant", 32'(grant), 32'd0);
    step();
`endif

    // random sweep of structural invariants
    p1 = '0;
    p2 = '0;
    for (int c = 0; c < 10000; c++) begin
      req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) rel = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 3) == 0) rel = grant;
      else rel = '0;
      step();
      chk("rnd onehot0", 32'($onehot0(grant)), 32'd1);
      chk("rnd busy", 32'(busy), 32'(|grant));
      chk("rnd owner", 32'(grant),
          busy ? (32'd1 << owner) : 32'd0);
      if (p1 == '0 && p2 != '0)
        chk("rnd recover", 32'(grant), 32'd0);
      p2 = p1;
      p1 = grant;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
